// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the
// sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_MAX    = 9999;

  // Bit i set when digit i is a leading zero.
  // The units digit is never blanked.
  function automatic logic [3:0] lz_mask_f(
    input logic [3:0] th,
    input logic [3:0] hu,
    input logic [3:0] te
  );
    logic z3;
    logic z2;
    logic z1;
    z3 = (th == 4'd0);
    z2 = z3 && (hu == 4'd0);
    z1 = z2 && (te == 4'd0);
    return {z3, z2, z1, 1'b0};
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: per-nibble correction used by the
// shift-and-add-3 converter.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) begin
      nib_o = nib_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one bit per clock binary to BCD,
// double-buffered digits, saturation, lz mask.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int MAX_VALUE = BCD_MAX
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       units,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic             overflow,
  output logic [3:0]       lz_mask
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);
  localparam logic [31:0] MAX_W =
    32'(MAX_VALUE);
  localparam logic [WIDTH-1:0] MAX_N =
    MAX_W[WIDTH-1:0];

  bcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [15:0]      dig_q, dig_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       lz_q, lz_d;
  logic             done_q, done_d;

  logic [15:0]      cor;
  logic             sat;

  for (genvar i = 0; i < BCD_DIGITS; i++)
  begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_q[4*i +: 4]),
      .nib_o (cor[4*i +: 4])
    );
  end

  assign sat = 32'(value) > MAX_W;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    lz_d    = lz_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          bin_d   = sat ? MAX_N : value;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = sat;
          state_d = SHIFT;
        end
      end
      (state_q == SHIFT): begin
        // MSB of the corrected thousands nibble
        // falls off; it is zero for legal inputs.
        {bcd_d, bin_d} = {cor, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      (state_q == DONE): begin
        dig_d   = bcd_q;
        ovf_d   = pend_q;
        lz_d    = lz_mask_f(bcd_q[15:12],
                            bcd_q[11:8],
                            bcd_q[7:4]);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      lz_q    <= 4'b1110;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      lz_q    <= lz_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign units     = dig_q[3:0];
  assign tens      = dig_q[7:4];
  assign hundreds  = dig_q[11:8];
  assign thousands = dig_q[15:12];
  assign overflow  = ovf_q;
  assign lz_mask   = lz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench with an
// arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int W = 14;
  localparam int LAT = W + 1;

  typedef struct {
    int th;
    int hu;
    int te;
    int un;
    int ovf;
    int lz;
    int due;
  } exp_t;

  logic         CLK;
  logic         RESET;
  logic         start;
  logic [W-1:0] value;
  logic         busy;
  logic         done;
  logic [3:0]   units;
  logic [3:0]   tens;
  logic [3:0]   hundreds;
  logic [3:0]   thousands;
  logic         overflow;
  logic [3:0]   lz_mask;

  int   n_pass;
  int   n_total;
  int   cyc;
  exp_t sb[$];
  exp_t held;

  bin2bcd_seq #(.WIDTH(W), .MAX_VALUE(9999)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .units     (units),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .overflow  (overflow),
    .lz_mask   (lz_mask)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name,
                     input int act,
                     input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  name, act, req);
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int s;
    s = (v > 9999) ? 9999 : v;
    e.th  = s / 1000;
    e.hu  = (s / 100) % 10;
    e.te  = (s / 10) % 10;
    e.un  = s % 10;
    e.ovf = (v > 9999) ? 1 : 0;
    e.lz  = 0;
    if (e.th == 0) e.lz |= 8;
    if (e.th == 0 && e.hu == 0) e.lz |= 4;
    if (e.th == 0 && e.hu == 0 && e.te == 0)
      e.lz |= 2;
    e.due = 0;
    return e;
  endfunction

  function automatic exp_t rst_val();
    exp_t e;
    e = model(0);
    return e;
  endfunction

  task automatic chk_outs(input string tag,
                          input exp_t e);
    chk({tag, ".th"}, int'(thousands), e.th);
    chk({tag, ".hu"}, int'(hundreds), e.hu);
    chk({tag, ".te"}, int'(tens), e.te);
    chk({tag, ".un"}, int'(units), e.un);
    chk({tag, ".ovf"}, int'(overflow), e.ovf);
    chk({tag, ".lz"}, int'(lz_mask), e.lz);
  endtask

  // Monitor: pop on done, otherwise outputs hold.
  always @(negedge CLK) begin
    if (RESET) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          held = sb.pop_front();
          chk_outs("result", held);
          chk("latency", cyc, held.due);
        end
      end else begin
        chk("hold.th", int'(thousands), held.th);
        chk("hold.lz", int'(lz_mask), held.lz);
        chk("hold.ovf", int'(overflow), held.ovf);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int v);
    exp_t e;
    wait_idle();
    start = 1'b1;
    value = W'(v);
    e = model(v);
    e.due = cyc + 1 + LAT;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic convert(input int v);
    issue(v);
    wait_idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    held    = rst_val();
    RESET   = 1'b0;
    start   = 1'b0;
    value   = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_outs("reset", rst_val());
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle.busy", int'(busy), 0);
    chk_outs("idle", rst_val());

    convert(1234);
    convert(7);
    convert(9999);
    convert(16383);
    convert(42);
    convert(1234);

    issue(500);
    repeat (4) @(posedge CLK);
    #1;
    start = 1'b1;
    value = W'(77);
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_idle();

    issue(1234);
    repeat (7) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    sb.delete();
    held = rst_val();
    chk_outs("midrst", rst_val());
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    chk("post_rst.busy", int'(busy), 0);
    convert(8765);

    convert(0);
    convert(10000);
    convert(9998);
    for (int i = 0; i < 30; i++) begin
      convert(int'($urandom_range(16383, 0)));
    end
    // Back-to-back with held start.
    issue(3141);
    start = 1'b1;
    value = W'(2718);
    wait_idle();
    begin
      exp_t e;
      e = model(2718);
      e.due = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_idle();

    repeat (3) @(posedge CLK);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that produces the four BCD digits consumed by `display_decoder`. It sits directly upstream of `display_decoder`: a counter or measurement value is loaded on a start pulse, and the converted digits drive D0..D3. Outputs are double-buffered, so the display never shows a partially converted value. It also provides a saturation flag and a leading-zero mask for blanking.

## Interface
- `WIDTH`, 14, width of binary input; legal range 4..14
- `MAX_VALUE`, 9999, largest representable value; larger inputs saturate
- `CLK`  in  1  system clock (50 MHz)
- `RESET`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; samples `value` when accepted
- `value`  in  WIDTH  unsigned binary to convert
- `busy`  out  1  high while a conversion is in progress
- `done`  out  1  one-cycle pulse when new digits are presented
- `units`, `tens`, `hundreds`, `thousands`  out  4 each  BCD digits to `display_decoder` D0..D3
- `overflow`  out  1  last accepted value exceeded MAX_VALUE
- `lz_mask`  out  4  bit i = 1 when digit i is a leading zero; bit 0 is always 0

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**:
  - When `start`=1, latch `value` into the binary shift register and clear the 16-bit BCD scratch register.
  - If `value` > MAX_VALUE, latch MAX_VALUE instead and set a pending overflow bit.
  - Clear the bit counter, set `busy`=1, go to SHIFT.
- **SHIFT**, once per cycle:
  - Each BCD nibble ≥5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - Increment the bit counter.
  - After WIDTH shifts, go to DONE.
- **DONE**, one cycle:
  - Copy scratch nibbles to output digit registers.
  - Copy the pending overflow bit to `overflow`.
  - Compute `lz_mask` from the new digits: bit 3 if thousands=0; bit 2 if thousands=0 and hundreds=0; bit 1 if upper three are 0; bit 0 always 0.
  - Pulse `done`, clear `busy`, return to IDLE.
- `start` while `busy`=1 or in DONE is ignored; it is not queued.
- Output digits, `overflow` and `lz_mask` change only on the DONE cycle. They hold their values otherwise.
- Saturation conversions take the same latency as normal ones.
- Arithmetic:
  - The add-3 compare is unsigned per nibble.
  - Nibbles never exceed 9 after the final shift for inputs ≤ MAX_VALUE.
  - Bit counter width is clog2(WIDTH+1).

## Timing
- Reset (asynchronous assert, any state, including mid-conversion):
  - State=IDLE, `busy`=0, `done`=0.
  - All digits=0, `overflow`=0, `lz_mask`=4'b1110.
  - Scratch registers cleared; the in-flight conversion is discarded.
- Reset release is synchronous to CLK via the registered state; the first `start` is accepted on the first edge after deassertion.
- Latency:
  - `start` sampled at edge 0.
  - WIDTH shifts occur on edges 1..WIDTH.
  - New digits and `done`=1 are visible after edge WIDTH+1 (15 cycles for WIDTH=14).
- `busy` is high from after edge 0 until after edge WIDTH+1.
- Back-to-back: a `start` held high or re-asserted on the cycle `done` is high is accepted, since the state is IDLE then. Throughput is one conversion per WIDTH+2 cycles.
- `start` coincident with reset deassertion is not guaranteed to be accepted.

## Structure
- Package `bcd_pkg`:
  - State enum `bcd_state_t` {IDLE, SHIFT, DONE}.
  - `BCD_DIGITS`=4, `BCD_MAX`=9999.
  - Function for the leading-zero mask.
- Sub-module `bcd_add3`: combinational 4-bit corrector (in ≥5 ? in+3 : in), instantiated four times.
- Everything else in one always_ff / always_comb pair in `bin2bcd_seq`.

## Test plan
- Reset, then idle: digits 0/0/0/0, `overflow`=0, `lz_mask`=1110, `busy`=0.
- `start` with `value`=1234: `done` exactly 15 cycles later; thousands=1, hundreds=2, tens=3, units=4; `lz_mask`=0000.
- `value`=7: digits 0/0/0/7, `lz_mask`=1110. Then `value`=9999: digits 9/9/9/9, `lz_mask`=0000, `overflow`=0.
- `value`=16383: digits 9/9/9/9, `overflow`=1, same 15-cycle latency. A following `value`=42 clears `overflow` and gives 0/0/4/2 with `lz_mask`=1100.
- `start` pulsed again 5 cycles into a conversion of 500 with `value`=77: ignored, result 0/5/0/0. Outputs hold 1234-era values until `done`.
- Assert RESET at shift 7 of a conversion: outputs return to reset values immediately, `done` never pulses. A new `start` after release converts correctly.
